alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: WIDTH, 32, result data width; all data ports below are WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream logic unit (AND/OR/XOR) presents a result.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 in_result  input  WIDTH  result word from the logic unit.
REQ-007 in_op  input  2  op tag: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 out_valid  output  1  head entry available downstream.
REQ-009 out_ready  input  1  downstream consumes head this cycle.
REQ-010 out_result  output  WIDTH  head result word.
REQ-011 out_op  output  2  op tag of head entry.
REQ-012 out_zero  output  1  head result equals 0.
REQ-013 out_neg  output  1  head result MSB.
REQ-014 out_parity  output  1  XOR-reduction of head result (1 = odd number of ones).
REQ-015 out_seq  output  16  count of completed pops, modulo 65536.
REQ-016 level  output  2  entries held (0, 1 or 2).

Function
REQ-017 Storage SHALL be a 2-entry FIFO, each entry {result, op, zero, neg, parity}; flags computed from in_result at push time.
REQ-018 State machine SHALL have states EMPTY (level 0), ONE (level 1), FULL (level 2); level SHALL mirror the state.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, derived only from registered state (no combinational path from out_ready or in_valid).
REQ-020 Push SHALL occur on an edge where in_valid and in_ready are both 1; pop SHALL occur on an edge where out_valid and out_ready are both 1.
REQ-021 out_valid SHALL be 1 exactly in ONE and FULL; out_* data SHALL show the oldest entry and be held stable while out_valid=1 and out_ready=0.
REQ-022 Latency: a result pushed on edge N SHALL appear on out_* from edge N (out_valid high the cycle after acceptance) when the FIFO was EMPTY.
REQ-023 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with new entry becoming head; FULL+pop->ONE; no other event changes state.
REQ-024 In FULL, in_valid SHALL be ignored (no overwrite, no data loss).
REQ-025 In EMPTY, out_ready SHALL be ignored (no pop, out_seq unchanged).
REQ-026 out_seq SHALL increment by 1 on every pop and wrap 0xFFFF->0x0000.
REQ-027 Entry order SHALL be strict FIFO; read/write pointers are 1 bit each and wrap 1->0.
REQ-028 When out_valid=0, out_result, out_op and all flags SHALL be driven 0.

Reset
REQ-029 With rst=1 at an edge: state EMPTY, level 0, out_valid 0, in_ready 1 from the next cycle, pointers 0, out_seq 0, all data/flag outputs 0.
REQ-030 rst SHALL override simultaneous push/pop on the same edge; held entries are discarded (reset mid-operation loses content).
REQ-031 in_ready SHALL be 1 during reset cycles, but no push SHALL occur while rst=1.

Verification
REQ-032 Push 0x0000FFFF op 00, out_ready=1 -> next cycle out_result 0x0000FFFF, zero 0, neg 0, parity 0; pop advances out_seq 0->1.
REQ-033 Push 0xFFFF0000 then 0x00000002 with out_ready=0 -> level 2, in_ready 0; head 0xFFFF0000 neg 1 parity 0; third push (0x3) ignored; then drain yields 0xFFFF0000, 0x00000002 (parity 1), level 0.
REQ-034 Push 0x00000000 op 11 -> out_zero 1, neg 0, parity 0, out_op 11.
REQ-035 Level 1, simultaneous push 0x00000003 and pop -> level stays 1, out_result becomes 0x00000003, out_seq +1.
REQ-036 Preload out_seq to 0xFFFF via 65535 pops, one more pop -> out_seq 0x0000.
REQ-037 Level 2, assert rst for one cycle with in_valid=1 and out_ready=1 -> level 0, out_valid 0, out_seq 0, all outputs 0 after that edge.

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry FIFO buffering logic-unit results with zero/neg/parity flags and a pop counter.
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_parity,
    output logic [15:0]      out_seq,
    output logic [1:0]       level
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state, next_state;
    logic [WIDTH-1:0] mem_result [2];
    logic [1:0]       mem_op [2];
    logic [2:0]       mem_flags [2];
    logic             wp, rp, push, pop;
    assign push = in_valid && in_ready && !rst;
    assign pop  = out_valid && out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            wp      <= 1'b0;
            rp      <= 1'b0;
            out_seq <= 16'd0;
        end else begin
            state <= next_state;
            if (push) wp <= ~wp;
            if (pop) begin
                rp      <= ~rp;
                out_seq <= out_seq + 16'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wp] <= in_result;
            mem_op[wp]     <= in_op;
            mem_flags[wp]  <= {~|in_result, in_result[WIDTH-1], ^in_result};
        end
    end
    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   next_state = push ? ONE : EMPTY;
            ONE:     next_state = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
            default: next_state = pop ? ONE : FULL;
        endcase
    end
    always_comb begin
        in_ready   = (state != FULL) || rst;
        out_valid  = state != EMPTY;
        level      = state;
        out_result = out_valid ? mem_result[rp] : '0;
        out_op     = out_valid ? mem_op[rp] : 2'b00;
        out_zero   = out_valid && mem_flags[rp][2];
        out_neg    = out_valid && mem_flags[rp][1];
        out_parity = out_valid && mem_flags[rp][0];
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: table-driven directed vectors plus reset and counter-wrap sequences.
module tb_alu_result_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_result, out_result;
    logic [1:0]  in_op, out_op, level;
    logic        out_zero, out_neg, out_parity;
    logic [15:0] out_seq;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        iv;
        logic [31:0] res;
        logic [1:0]  op;
        logic        ordy;
        logic        ev;
        logic        erdy;
        logic [1:0]  elvl;
        logic [31:0] eres;
        logic [1:0]  eop;
        logic        ez;
        logic        en;
        logic        ep;
        logic [15:0] eseq;
    } vec_t;
    vec_t vecs [14];

    alu_result_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
        .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity),
        .out_seq(out_seq), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic erdy, input logic [1:0] elvl,
                           input logic [31:0] eres, input logic [1:0] eop, input logic ez,
                           input logic en, input logic ep, input logic [15:0] eseq);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, erdy});
        chk({tag, ".level"}, {30'd0, level}, {30'd0, elvl});
        chk({tag, ".out_result"}, out_result, eres);
        chk({tag, ".out_op"}, {30'd0, out_op}, {30'd0, eop});
        chk({tag, ".flags"}, {29'd0, out_zero, out_neg, out_parity}, {29'd0, ez, en, ep});
        chk({tag, ".out_seq"}, {16'd0, out_seq}, {16'd0, eseq});
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000FFFF, 2'b00, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0000FFFF, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 32'h00000000, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[2]  = '{1'b1, 32'hFFFF0000, 2'b01, 1'b0, 1'b1, 1'b1, 2'd1, 32'hFFFF0000, 2'b01, 1'b0, 1'b1, 1'b0, 16'd1};
        vecs[3]  = '{1'b1, 32'h00000002, 2'b10, 1'b0, 1'b1, 1'b0, 2'd2, 32'hFFFF0000, 2'b01, 1'b0, 1'b1, 1'b0, 16'd1};
        vecs[4]  = '{1'b1, 32'h00000003, 2'b00, 1'b0, 1'b1, 1'b0, 2'd2, 32'hFFFF0000, 2'b01, 1'b0, 1'b1, 1'b0, 16'd1};
        vecs[5]  = '{1'b1, 32'h00000003, 2'b00, 1'b1, 1'b1, 1'b1, 2'd1, 32'h00000002, 2'b10, 1'b0, 1'b0, 1'b1, 16'd2};
        vecs[6]  = '{1'b0, 32'h00000000, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b0, 16'd3};
        vecs[7]  = '{1'b1, 32'h00000000, 2'b11, 1'b0, 1'b1, 1'b1, 2'd1, 32'h00000000, 2'b11, 1'b1, 1'b0, 1'b0, 16'd3};
        vecs[8]  = '{1'b1, 32'h00000003, 2'b00, 1'b1, 1'b1, 1'b1, 2'd1, 32'h00000003, 2'b00, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[9]  = '{1'b0, 32'h00000000, 2'b00, 1'b0, 1'b1, 1'b1, 2'd1, 32'h00000003, 2'b00, 1'b0, 1'b0, 1'b0, 16'd4};
        vecs[10] = '{1'b0, 32'h00000000, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b0, 16'd5};
        vecs[11] = '{1'b0, 32'h00000000, 2'b00, 1'b1, 1'b0, 1'b1, 2'd0, 32'h00000000, 2'b00, 1'b0, 1'b0, 1'b0, 16'd5};
        vecs[12] = '{1'b1, 32'h80000001, 2'b10, 1'b0, 1'b1, 1'b1, 2'd1, 32'h80000001, 2'b10, 1'b0, 1'b1, 1'b0, 16'd5};
        vecs[13] = '{1'b1, 32'h00000007, 2'b01, 1'b0, 1'b1, 1'b0, 2'd2, 32'h80000001, 2'b10, 1'b0, 1'b1, 1'b0, 16'd5};

        rst = 1'b1; in_valid = 1'b1; in_result = 32'h12345678; in_op = 2'b01; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b1, 2'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        for (int i = 0; i < 14; i++) begin
            in_valid = vecs[i].iv; in_result = vecs[i].res; in_op = vecs[i].op; out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erdy, vecs[i].elvl, vecs[i].eres,
                    vecs[i].eop, vecs[i].ez, vecs[i].en, vecs[i].ep, vecs[i].eseq);
        end

        // FIFO is FULL here; reset with push and pop requested must discard everything
        rst = 1'b1; in_valid = 1'b1; in_result = 32'hDEADBEEF; in_op = 2'b11; out_ready = 1'b1;
        #1;
        chk("rst_in_ready_comb", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk_all("rst_mid", 1'b0, 1'b1, 2'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        in_valid = 1'b1; in_result = 32'hA5A5A5A5; in_op = 2'b01;
        @(posedge clk);
        #1;
        chk("wrap_prime_level", {30'd0, level}, 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            in_result = i;
            @(posedge clk);
            #1;
        end
        chk("wrap_seq_ffff", {16'd0, out_seq}, 32'h0000FFFF);
        chk("wrap_head", out_result, 32'd65535);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap_seq_zero", {16'd0, out_seq}, 32'd0);
        chk("wrap_level", {30'd0, level}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
